aes_encipher_block: RTL and testbench
=====================================

# aes_encipher_block

Iterative AES-128/AES-256 encryption datapath, one full round per clock. It sits directly downstream of the round-key memory. It drives the round index to that memory and consumes the 128-bit round key returned combinationally in the same cycle. It accepts one plaintext block per `next` pulse and presents the ciphertext with a `ready` flag.

## Interface
Parameters:
- none. Key length is selected at run time by `keylen`.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `next` in 1: start-encryption strobe; honoured only when `ready`=1.
- `keylen` in 1: 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled on acceptance.
- `block` in 128: plaintext, byte 0 in bits [127:120]; sampled on acceptance.
- `round` out 4: round index to the key memory, equal to the round-counter register.
- `round_key` in 128: round key for `round`, valid combinationally in the same cycle.
- `new_block` out 128: state register; holds the ciphertext while `ready`=1.
- `ready` out 1: 1 = idle and `new_block` valid or never written.

## Operation
- The FSM has two states:
  - CTRL_IDLE: `round`=0, so `round_key` carries rk[0].
  - CTRL_ROUNDS: round counter r runs from 1 to Nr.
- Acceptance (CTRL_IDLE with `next`=1):
  - state <= `block` ^ `round_key` (initial AddRoundKey);
  - keylen_reg <= `keylen`; r <= 1; `ready` <= 0; go to CTRL_ROUNDS.
- CTRL_ROUNDS with r < Nr:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ `round_key`; r <= r+1.
- CTRL_ROUNDS with r = Nr:
  - state <= ShiftRows(SubBytes(state)) ^ `round_key`, with no MixColumns;
  - r <= 0; `ready` <= 1; go to CTRL_IDLE.
- Nr comes from keylen_reg, never from the live `keylen` port. A `keylen` change mid-operation has no effect.
- `next` in CTRL_ROUNDS is ignored; there is no queueing.
- Arithmetic:
  - MixColumns is over GF(2^8) with polynomial 0x11b;
  - xtime(b) = {b[6:0],0} ^ (0x1b & {8{b[7]}});
  - column mix is 02·a0 ^ 03·a1 ^ a2 ^ a3, rotated per row.
- Column-major state: column c = bits [127-32c : 96-32c]; ShiftRows rotates row i left by i bytes.
- The upstream key memory must have completed key expansion (its ready=1) before `next` is issued. This block does not check that condition.

## Timing
- Reset values: `ready`=1, `new_block`=0, `round`=0, FSM = CTRL_IDLE, keylen_reg=0.
- Latency: acceptance edge plus Nr round edges = Nr+1 rising edges from sampling `next`=1 to `ready`=1.
  - AES-128: 11 edges.
  - AES-256: 15 edges.
- `ready` falls on the acceptance edge and rises on the same edge that writes the final ciphertext. `new_block` is stable while `ready`=1.
- `round` sequence after acceptance: 1, 2, …, Nr, then 0. This equals the counter register and has no combinational path from `next`.
- Back-to-back operation: `next` asserted in the cycle `ready` rises is accepted. Throughput is Nr+1 cycles per block.
- `reset_n` low at any time aborts the operation immediately: all reset values apply and any partial ciphertext is discarded.
- `next` held high continuously restarts an encryption each time the block returns to idle.

## Structure
- Shared package `aes_pkg` holds:
  - AES_128_BIT_KEY / AES_256_BIT_KEY;
  - AES_128_NUM_ROUNDS=10 and AES_256_NUM_ROUNDS=14;
  - CTRL_IDLE / CTRL_ROUNDS encodings;
  - gf_xtime, gf_mul2/gf_mul3 and mixcolumn functions, shared with a future decipher block.
- Sub-module `aes_sbox`: 32-bit in, 32-bit out, combinational (4 byte S-boxes). It is instantiated 4 times to cover the 128-bit state in one cycle.
- State register, round counter, keylen_reg and FSM are local.

## Test plan
The bench models the key memory as a precomputed rk[0..Nr] array indexed by `round`.
- Reset check: release `reset_n` -> `ready`=1, `new_block`=0, `round`=0.
- FIPS-197 App. B, AES-128:
  - key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> `new_block`=3925841d02dc09fbdc118597196a0b32 exactly 11 edges after `next`;
  - `round` steps 1..10 then 0.
- FIPS-197 C.1 AES-128, then C.3 AES-256 back-to-back:
  - key 000102…0f, block 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a;
  - key 000102…1f, same block -> 8ea2b7ca516745bfeafc49904b496089 after 15 edges;
  - the second `next` is issued in the cycle `ready` rises.
- Busy-ignore: pulse `next` and toggle `keylen` at round 5 of an AES-128 run -> result unchanged, still 11 edges, no restart.
- Mid-run reset: assert `reset_n`=0 at round 7 -> `ready`=1 and `new_block`=0 asynchronously; a following C.1 run gives the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared constants and GF(2^8) helpers.
// Used by the encipher datapath and a future decipher block.
package aes_pkg;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

    localparam logic [0:0] CTRL_IDLE   = 1'b0;
    localparam logic [0:0] CTRL_ROUNDS = 1'b1;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return gf_xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return gf_xtime(b) ^ b;
    endfunction

    function automatic logic [31:0] mixcolumn(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gf_mul2(b0) ^ gf_mul3(b1) ^ b2 ^ b3,
                b0 ^ gf_mul2(b1) ^ gf_mul3(b2) ^ b3,
                b0 ^ b1 ^ gf_mul2(b2) ^ gf_mul3(b3),
                gf_mul3(b0) ^ b1 ^ b2 ^ gf_mul2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixcolumn(s[127:96]), mixcolumn(s[95:64]),
                mixcolumn(s[63:32]), mixcolumn(s[31:0])};
    endfunction

    // byte (row r, col c) sits at index 4c+r, byte 0 in the top bits
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four parallel AES forward S-boxes on one 32-bit word.
// Purely combinational table lookup.
module aes_sbox (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    assign o_word = {sb(i_word[31:24]), sb(i_word[23:16]),
                     sb(i_word[15:8]),  sb(i_word[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath, one round per clock.
// Round key arrives combinationally from the key memory for the current round.
module aes_encipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready
);

    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic         r_keylen;
    logic         r_ready;
    logic [0:0]   r_ctrl;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [3:0]   w_nr;
    logic         w_last;

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_word (r_state[127-32*i -: 32]),
            .o_word (w_sub[127-32*i -: 32])
        );
    end

    assign w_shift = shiftrows(w_sub);
    assign w_mix   = mixcolumns(w_shift);

    // Nr follows the latched key length, never the live port
    always_comb begin
        w_nr = AES_128_NUM_ROUNDS;
        unique case (1'b1)
            r_keylen == AES_128_BIT_KEY: w_nr = AES_128_NUM_ROUNDS;
            r_keylen == AES_256_BIT_KEY: w_nr = AES_256_NUM_ROUNDS;
        endcase
    end

    assign w_last = (r_round == w_nr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= '0;
            r_round  <= '0;
            r_keylen <= 1'b0;
            r_ready  <= 1'b1;
            r_ctrl   <= CTRL_IDLE;
        end else begin
            unique case (1'b1)
                r_ctrl == CTRL_IDLE: begin
                    if (next) begin
                        r_state  <= block ^ round_key;
                        r_keylen <= keylen;
                        r_round  <= 4'd1;
                        r_ready  <= 1'b0;
                        r_ctrl   <= CTRL_ROUNDS;
                    end
                end
                r_ctrl == CTRL_ROUNDS: begin
                    if (w_last) begin
                        r_state <= w_shift ^ round_key;
                        r_round <= 4'd0;
                        r_ready <= 1'b1;
                        r_ctrl  <= CTRL_IDLE;
                    end else begin
                        r_state <= w_mix ^ round_key;
                        r_round <= r_round + 4'd1;
                    end
                end
            endcase
        end
    end

    assign round     = r_round;
    assign new_block = r_state;
    assign ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed bench for aes_encipher_block using FIPS-197 vectors.
// Key memory is modelled by an independent key expansion indexed by round.
module tb_aes_encipher_block;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] new_block;
    logic         ready;

    int n_checks;
    int n_errors;

    logic [7:0]   sb [256];
    logic [127:0] rk [16];

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .block     (block),
        .round     (round),
        .round_key (round_key),
        .new_block (new_block),
        .ready     (ready)
    );

    assign round_key = rk[round];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from the field inverse plus the affine map
    task automatic build_sbox();
        logic [7:0] v;
        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                      ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key, input logic kl);
        int nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Starts right after an edge with ready=1; poke_at disturbs inputs
    // during that round, reset_at aborts the run during that round.
    task automatic encrypt(input string tag, input logic [127:0] blk,
                           input logic kl, input logic [127:0] exp,
                           input int poke_at, input int reset_at);
        int  nr, edges;
        bit  done;
        nr = kl ? 14 : 10;
        next = 1'b1; block = blk; keylen = kl;
        tick();
        next = 1'b0;
        edges = 1;
        check({tag, "_busy"}, 128'(ready), 128'(0));
        check({tag, "_r1"}, 128'(round), 128'(1));
        done = 1'b0;
        while (!done && edges < 40) begin
            if (edges == poke_at) begin
                next = 1'b1; keylen = ~kl; block = ~blk;
            end
            if (edges == reset_at) begin
                reset_n = 1'b0;
                #1;
                check({tag, "_rst_ready"}, 128'(ready), 128'(1));
                check({tag, "_rst_blk"}, new_block, 128'(0));
                check({tag, "_rst_round"}, 128'(round), 128'(0));
                #2 reset_n = 1'b1;
                return;
            end
            tick();
            edges++;
            next = 1'b0; keylen = kl;
            if (ready) done = 1'b1;
            else check({tag, "_round"}, 128'(round), 128'(edges));
        end
        check({tag, "_edges"}, 128'(edges), 128'(nr + 1));
        check({tag, "_rnd0"}, 128'(round), 128'(0));
        check({tag, "_ct"}, new_block, exp);
    endtask

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        build_sbox();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_blk", new_block, 128'(0));
        check("reset_round", 128'(round), 128'(0));

        load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
        encrypt("appb", 128'h3243f6a8885a308d313198a2e0370734, 1'b0,
                128'h3925841d02dc09fbdc118597196a0b32, -1, -1);

        load_key(KEY_C1, 1'b0);
        encrypt("c1", PT_C, 1'b0, CT_C1, -1, -1);
        load_key(KEY_C3, 1'b1);
        encrypt("c3", PT_C, 1'b1,
                128'h8ea2b7ca516745bfeafc49904b496089, -1, -1);

        load_key(KEY_C1, 1'b0);
        encrypt("busy", PT_C, 1'b0, CT_C1, 5, -1);
        repeat (3) tick();
        check("hold_ready", 128'(ready), 128'(1));
        check("hold_blk", new_block, CT_C1);

        encrypt("abort", PT_C, 1'b0, CT_C1, -1, 7);
        tick();
        encrypt("after", PT_C, 1'b0, CT_C1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
